// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone B4 pipelined initiator.
// Holds bus-width defaults, the FSM state encoding and the response status.
// Imported by wb_master_core and wb_watchdog.
package wb_pkg;

  localparam int WB_ADDR_WIDTH = 16;
  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_GRANULE    = 8;
  localparam int WB_SEL_WIDTH  = WB_DATA_WIDTH / WB_GRANULE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } wb_mst_state_e;

  typedef struct packed {
    logic err;
    logic timeout;
  } wb_rsp_status_t;

endpackage

// File: rtl/wb_watchdog.sv
// Cycle watchdog for one outstanding bus transaction; expired_o is combinational.
// expired_o rises in the cycle whose closing edge would make the count reach TIMEOUT.
// No backpressure; count saturates at TIMEOUT and never wraps; TIMEOUT=0 never expires.
module wb_watchdog
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_SAT  = CW'(TIMEOUT);

  logic [CW-1:0] r_count;

  // Count enabled cycles, restart on each new request, hold at the saturation value.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_count <= '0;
    end else if (en_i && (r_count != CNT_SAT)) begin
      r_count <= r_count + CW'(1);
    end
  end

  // Flag the cycle whose edge completes the TIMEOUT-th counted cycle.
  assign expired_o = (TIMEOUT != 0) && en_i && (r_count >= CNT_LAST);

endmodule

// File: rtl/wb_master_core.sv
// Wishbone B4 pipelined initiator: one local read/write command -> one bus cycle -> one response.
// Latency: accept edge, then >=1 strobe cycle, RESP entered on the ack/err/timeout edge.
// Backpressure: cmd_ready_o only in IDLE; response held in RESP until rsp_ready_i.
module wb_master_core
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int GRANULE    = WB_GRANULE,
  parameter int TIMEOUT    = 255,
  localparam int SEL_WIDTH = DATA_WIDTH / GRANULE
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [DATA_WIDTH-1:0] cmd_dat_i,
  input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic [SEL_WIDTH-1:0]  sel_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic                  ack_i,
  input  logic                  err_i,
  input  logic                  stall_i
);

  wb_mst_state_e   r_state, w_state_nxt;
  logic            r_cyc, w_cyc_nxt;
  logic            r_stb, w_stb_nxt;
  logic            r_we, w_we_nxt;
  logic [ADDR_WIDTH-1:0] r_adr, w_adr_nxt;
  logic [DATA_WIDTH-1:0] r_dat, w_dat_nxt;
  logic [SEL_WIDTH-1:0]  r_sel, w_sel_nxt;
  logic            r_rsp_vld, w_rsp_vld_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_dat, w_rsp_dat_nxt;
  wb_rsp_status_t  r_status, w_status_nxt;

  logic w_wd_clr, w_wd_en, w_wd_expired;
  logic w_finish, w_timeout;

  assign w_wd_clr = (r_state == IDLE) && cmd_valid_i;
  assign w_wd_en  = (r_state == REQ) || (r_state == WAIT);

  wb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (w_wd_clr),
    .en_i      (w_wd_en),
    .expired_o (w_wd_expired)
  );

  // Next-state and next-output decode; every register holds unless a transition updates it.
  always_comb begin
    w_state_nxt   = r_state;
    w_cyc_nxt     = r_cyc;
    w_stb_nxt     = r_stb;
    w_we_nxt      = r_we;
    w_adr_nxt     = r_adr;
    w_dat_nxt     = r_dat;
    w_sel_nxt     = r_sel;
    w_rsp_vld_nxt = r_rsp_vld;
    w_rsp_dat_nxt = r_rsp_dat;
    w_status_nxt  = r_status;
    w_finish      = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid_i) begin
          w_we_nxt    = cmd_we_i;
          w_adr_nxt   = cmd_adr_i;
          w_dat_nxt   = cmd_dat_i;
          w_sel_nxt   = cmd_sel_i;
          w_cyc_nxt   = 1'b1;
          w_stb_nxt   = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        // A stalled strobe was not taken, so any ack/err then cannot belong to it.
        if (!stall_i && (ack_i || err_i)) begin
          w_finish = 1'b1;
        end else if (w_wd_expired) begin
          w_timeout = 1'b1;
        end else if (!stall_i) begin
          w_stb_nxt   = 1'b0;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (ack_i || err_i) begin
          w_finish = 1'b1;
        end else if (w_wd_expired) begin
          w_timeout = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          w_rsp_vld_nxt = 1'b0;
          w_rsp_dat_nxt = '0;
          w_status_nxt  = '0;
          w_state_nxt   = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Completion drops the bus cycle on the same edge the response is loaded; err beats ack.
    if (w_finish || w_timeout) begin
      w_state_nxt          = RESP;
      w_cyc_nxt            = 1'b0;
      w_stb_nxt            = 1'b0;
      w_rsp_vld_nxt        = 1'b1;
      w_status_nxt.err     = w_finish && err_i;
      w_status_nxt.timeout = w_timeout;
      w_rsp_dat_nxt        = (w_finish && !err_i && !r_we) ? dat_i : '0;
    end
  end

  // State and output registers; reset abandons any bus cycle and pending response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_sel     <= '0;
      r_rsp_vld <= 1'b0;
      r_rsp_dat <= '0;
      r_status  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cyc     <= w_cyc_nxt;
      r_stb     <= w_stb_nxt;
      r_we      <= w_we_nxt;
      r_adr     <= w_adr_nxt;
      r_dat     <= w_dat_nxt;
      r_sel     <= w_sel_nxt;
      r_rsp_vld <= w_rsp_vld_nxt;
      r_rsp_dat <= w_rsp_dat_nxt;
      r_status  <= w_status_nxt;
    end
  end

  assign cmd_ready_o   = (r_state == IDLE);
  assign cyc_o         = r_cyc;
  assign stb_o         = r_stb;
  assign we_o          = r_we;
  assign adr_o         = r_adr;
  assign dat_o         = r_dat;
  assign sel_o         = r_sel;
  assign rsp_valid_o   = r_rsp_vld;
  assign rsp_dat_o     = r_rsp_dat;
  assign rsp_err_o     = r_status.err;
  assign rsp_timeout_o = r_status.timeout;

endmodule

// File: tb/tb_wb_master_core.sv
// Directed bench for wb_master_core with an 8-cycle watchdog.
// Inputs change and outputs are sampled 1ns after each rising edge.
// Counting the accept cycle as cycle 1, a zero-wait slave yields rsp_valid in cycle 3.
module tb_wb_master_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [15:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        cyc, stb, we;
  logic [15:0] adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic [31:0] rdat = '0;
  logic        ack = 1'b0;
  logic        err = 1'b0;
  logic        stall = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  wb_master_core #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .GRANULE(8), .TIMEOUT(8)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
    .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(wdat), .sel_o(sel),
    .dat_i(rdat), .ack_i(ack), .err_i(err), .stall_i(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---- reset state
    step(); step();
    chk("rst_cyc", cyc, 0);        chk("rst_stb", stb, 0);
    chk("rst_we", we, 0);          chk("rst_adr", adr, 0);
    chk("rst_dat", wdat, 0);       chk("rst_sel", sel, 0);
    chk("rst_rsp_valid", rsp_valid, 0); chk("rst_rsp_dat", rsp_dat, 0);
    chk("rst_err", rsp_err, 0);    chk("rst_timeout", rsp_timeout, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    rst = 1'b0;
    step();

    // ---- write, zero-wait slave acking in the strobe cycle
    cmd_valid = 1; cmd_we = 1; cmd_adr = 16'h0010; cmd_dat = 32'hDEADBEEF; cmd_sel = 4'hF;
    chk("w_ready_before", cmd_ready, 1);
    step();                                   // accept edge
    cmd_valid = 0;
    chk("w_cyc", cyc, 1); chk("w_stb", stb, 1); chk("w_we", we, 1);
    chk("w_adr", adr, 16'h0010); chk("w_dat", wdat, 32'hDEADBEEF); chk("w_sel", sel, 4'hF);
    chk("w_rsp_early", rsp_valid, 0); chk("w_ready_busy", cmd_ready, 0);
    ack = 1;
    step();
    ack = 0;
    chk("w_rsp_valid", rsp_valid, 1); chk("w_rsp_err", rsp_err, 0);
    chk("w_rsp_timeout", rsp_timeout, 0); chk("w_rsp_dat", rsp_dat, 0);
    chk("w_cyc_drop", cyc, 0); chk("w_stb_drop", stb, 0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("w_rsp_done", rsp_valid, 0); chk("w_ready_back", cmd_ready, 1);

    // ---- read, 3 stalled strobe cycles then 2 wait cycles
    cmd_valid = 1; cmd_we = 0; cmd_adr = 16'h0024; cmd_dat = 32'h0; cmd_sel = 4'h3;
    step();
    cmd_valid = 0; cmd_adr = 16'hFFFF; stall = 1;
    for (int i = 0; i < 3; i++) begin
      chk("r_stall_stb", stb, 1); chk("r_stall_adr", adr, 16'h0024);
      chk("r_stall_we", we, 0);   chk("r_stall_sel", sel, 4'h3);
      step();
    end
    chk("r_stb4", stb, 1); chk("r_adr4", adr, 16'h0024);
    stall = 0;
    step();
    chk("r_wait1_cyc", cyc, 1); chk("r_wait1_stb", stb, 0); chk("r_wait1_vld", rsp_valid, 0);
    step();
    chk("r_wait2_cyc", cyc, 1); chk("r_wait2_vld", rsp_valid, 0);
    ack = 1; rdat = 32'h12345678;
    step();
    ack = 0; rdat = 32'h0BADF00D;
    chk("r_rsp_valid", rsp_valid, 1); chk("r_rsp_dat", rsp_dat, 32'h12345678);
    chk("r_cyc_resp", cyc, 0); chk("r_err", rsp_err, 0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("r_done", rsp_valid, 0);

    // ---- error with ack and err together
    cmd_valid = 1; cmd_we = 0; cmd_adr = 16'h0030; cmd_sel = 4'hF;
    step();
    cmd_valid = 0;
    ack = 1; err = 1; rdat = 32'hAAAA5555;
    step();
    ack = 0; err = 0;
    chk("e_cyc", cyc, 0); chk("e_valid", rsp_valid, 1);
    chk("e_err", rsp_err, 1); chk("e_dat", rsp_dat, 0); chk("e_timeout", rsp_timeout, 0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("e_err_clr", rsp_err, 0); chk("e_ready", cmd_ready, 1);

    // ---- watchdog: slave never answers
    cmd_valid = 1; cmd_we = 0; cmd_adr = 16'h0040;
    step();                                   // stb rises here
    cmd_valid = 0; rdat = 32'h77777777;
    for (int k = 1; k < 8; k++) begin
      chk("t_pending_vld", rsp_valid, 0); chk("t_pending_cyc", cyc, 1);
      step();
    end
    chk("t_pending_last", rsp_valid, 0);
    step();                                   // 8 cycles after stb rose
    chk("t_timeout", rsp_timeout, 1); chk("t_valid", rsp_valid, 1);
    chk("t_cyc", cyc, 0); chk("t_dat", rsp_dat, 0); chk("t_err", rsp_err, 0);
    ack = 1;
    step();
    ack = 0;
    chk("t_late_ack_to", rsp_timeout, 1); chk("t_late_ack_dat", rsp_dat, 0);
    chk("t_late_ack_cyc", cyc, 0); chk("t_ready_held", cmd_ready, 0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("t_to_clr", rsp_timeout, 0); chk("t_ready_back", cmd_ready, 1);

    // ---- response back-pressure with a queued command
    cmd_valid = 1; cmd_we = 0; cmd_adr = 16'h0050;
    step();
    cmd_we = 1; cmd_adr = 16'h0060; cmd_dat = 32'h01020304; cmd_sel = 4'hC;
    ack = 1; rdat = 32'hCAFEF00D;
    step();
    ack = 0; rdat = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1); chk("bp_dat", rsp_dat, 32'hCAFEF00D);
      chk("bp_ready", cmd_ready, 0); chk("bp_cyc", cyc, 0);
      step();
    end
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("bp_done", rsp_valid, 0); chk("bp_not_yet", cyc, 0); chk("bp_idle", cmd_ready, 1);
    step();
    cmd_valid = 0;
    chk("bp_next_cyc", cyc, 1); chk("bp_next_adr", adr, 16'h0060);
    chk("bp_next_we", we, 1); chk("bp_next_sel", sel, 4'hC);
    ack = 1; rdat = 32'h55AA55AA;
    step();
    ack = 0;
    chk("bp_wr_dat", rsp_dat, 0); chk("bp_wr_valid", rsp_valid, 1);
    rsp_ready = 1;
    step();
    rsp_ready = 0;

    // ---- reset while waiting for ack
    cmd_valid = 1; cmd_we = 0; cmd_adr = 16'h0070;
    step();
    cmd_valid = 0;
    step();
    chk("rw_in_wait_cyc", cyc, 1); chk("rw_in_wait_stb", stb, 0);
    rst = 1;
    step();
    rst = 0;
    chk("rw_cyc", cyc, 0); chk("rw_stb", stb, 0); chk("rw_valid", rsp_valid, 0);
    chk("rw_adr", adr, 0);
    step();
    chk("rw_ready", cmd_ready, 1); chk("rw_still_idle", cyc, 0);
    ack = 1;
    step();
    ack = 0;
    chk("rw_no_rsp", rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
